// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the unified-memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    I_WAIT,
    D_WAIT
  } arb_state_t;

  typedef enum logic {
    PORT_I,
    PORT_D
  } arb_port_t;

  localparam int unsigned DEF_ADDR_W = 32;
  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_MEM_AW = 6;

endpackage

// File: rtl/mem_arbiter_pick.sv
// Winner selection between fetch and data requesters.
// Define MEM_ARB_RR_EN for round-robin on simultaneous requests; otherwise data always wins.
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic      i_req,
  input  logic      d_req,
  input  arb_port_t last_grant,
  output logic      grant_valid,
  output arb_port_t grant
);

  assign grant_valid = i_req | d_req;

`ifdef MEM_ARB_RR_EN
  always_comb begin
    if (i_req && d_req) begin
      grant = (last_grant == PORT_D) ? PORT_I : PORT_D;
    end else begin
      grant = d_req ? PORT_D : PORT_I;
    end
  end
`else
  logic unused_last_grant;
  assign unused_last_grant = (last_grant == PORT_D);
  assign grant = d_req ? PORT_D : PORT_I;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter serialising MIPS fetch and data accesses, one access per two cycles.
// Optional MEM_ARB_RR_EN enables round-robin arbitration (see arb_pick).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned MEM_AW = DEF_MEM_AW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              m_en,
  output logic              m_we,
  output logic [MEM_AW-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata
);

  arb_state_t        state, state_nx;
  logic              grant_valid;
  arb_port_t         grant;
  arb_port_t         last_grant;
  logic              d_we_q;
  logic [DATA_W-1:0] i_hold, d_hold;
  logic [MEM_AW-1:0] i_waddr, d_waddr;

  assign i_waddr = i_addr[MEM_AW+1:2];
  assign d_waddr = d_addr[MEM_AW+1:2];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_addr[1:0], d_addr[1:0],
                              i_addr[ADDR_W-1:MEM_AW+2], d_addr[ADDR_W-1:MEM_AW+2]};

  arb_pick u_pick (
    .i_req      (i_req),
    .d_req      (d_req),
    .last_grant (last_grant),
    .grant_valid(grant_valid),
    .grant      (grant)
  );

`ifdef MEM_ARB_RR_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= PORT_I;
    end else if (state == IDLE && grant_valid) begin
      last_grant <= grant;
    end
  end
`else
  assign last_grant = PORT_I;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      d_we_q <= 1'b0;
      i_hold <= '0;
      d_hold <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && grant_valid && grant == PORT_D) begin
        d_we_q <= d_we;
      end
      if (state == I_WAIT) begin
        i_hold <= m_rdata;
      end
      if (state == D_WAIT && !d_we_q) begin
        d_hold <= m_rdata;
      end
    end
  end

  // Reset gates every output so a WAIT cycle under reset produces no ready pulse.
  always_comb begin
    state_nx = state;
    m_en     = 1'b0;
    m_we     = 1'b0;
    m_addr   = '0;
    m_wdata  = '0;
    i_ready  = 1'b0;
    d_ready  = 1'b0;
    i_rdata  = i_hold;
    d_rdata  = d_hold;
    if (reset) begin
      i_rdata  = '0;
      d_rdata  = '0;
      state_nx = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (grant_valid) begin
            m_en    = 1'b1;
            m_wdata = d_wdata;
            if (grant == PORT_D) begin
              m_we     = d_we;
              m_addr   = d_waddr;
              state_nx = D_WAIT;
            end else begin
              m_addr   = i_waddr;
              state_nx = I_WAIT;
            end
          end
        end
        I_WAIT: begin
          i_ready  = 1'b1;
          i_rdata  = m_rdata;
          state_nx = IDLE;
        end
        D_WAIT: begin
          d_ready = 1'b1;
          if (!d_we_q) begin
            d_rdata = m_rdata;
          end
          state_nx = IDLE;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed literal checks plus randomized traffic against a transaction-level model.
module tb_mem_arbiter;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned MEM_AW = 6;
  localparam int unsigned DEPTH  = 1 << MEM_AW;
`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              i_req, d_req, d_we;
  logic [ADDR_W-1:0] i_addr, d_addr;
  logic [DATA_W-1:0] d_wdata, i_rdata, d_rdata, m_wdata;
  logic [DATA_W-1:0] m_rdata;
  logic              i_ready, d_ready, m_en, m_we;
  logic [MEM_AW-1:0] m_addr;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_AW(MEM_AW)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM serving the DUT.
  logic [DATA_W-1:0] ram [DEPTH];
  always @(posedge clk) begin
    if (m_en) begin
      if (m_we) ram[m_addr] <= m_wdata;
      else      m_rdata     <= ram[m_addr];
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level reference: memory image, one outstanding access, per-port held words.
  logic [DATA_W-1:0] ref_mem [DEPTH];
  bit                pend = 1'b0, pend_d, pend_we, last_d = 1'b0;
  int unsigned       pend_wa;
  logic [DATA_W-1:0] ref_ih = '0, ref_dh = '0;

  always @(negedge clk) begin
    bit                win_d;
    int unsigned       wa;
    logic [DATA_W-1:0] e_ird, e_drd;
    e_ird = ref_ih;
    e_drd = ref_dh;
    if (reset) begin
      check("rst_m_en", m_en, 0);   check("rst_m_we", m_we, 0);
      check("rst_m_addr", m_addr, 0); check("rst_m_wdata", m_wdata, 0);
      check("rst_i_ready", i_ready, 0); check("rst_d_ready", d_ready, 0);
      check("rst_i_rdata", i_rdata, 0); check("rst_d_rdata", d_rdata, 0);
      pend = 0; ref_ih = '0; ref_dh = '0; last_d = 0;
    end else if (pend) begin
      if (!pend_d) begin
        e_ird = ref_mem[pend_wa]; ref_ih = e_ird;
      end else if (!pend_we) begin
        e_drd = ref_mem[pend_wa]; ref_dh = e_drd;
      end
      check("wait_m_en", m_en, 0); check("wait_m_we", m_we, 0);
      check("i_ready", i_ready, !pend_d); check("d_ready", d_ready, pend_d);
      check("i_rdata", i_rdata, e_ird); check("d_rdata", d_rdata, e_drd);
      pend = 0;
    end else if (i_req || d_req) begin
      win_d = d_req && !(RR && i_req && last_d);
      wa = ((win_d ? d_addr : i_addr) >> 2) % DEPTH;
      check("issue_m_en", m_en, 1);
      check("issue_m_we", m_we, win_d && d_we);
      check("issue_m_addr", m_addr, wa);
      if (win_d && d_we) check("issue_m_wdata", m_wdata, d_wdata);
      check("issue_i_ready", i_ready, 0); check("issue_d_ready", d_ready, 0);
      check("issue_i_rdata", i_rdata, e_ird); check("issue_d_rdata", d_rdata, e_drd);
      if (win_d && d_we) ref_mem[wa] = d_wdata;
      pend = 1; pend_d = win_d; pend_we = win_d && d_we; pend_wa = wa; last_d = win_d;
    end else begin
      check("idle_m_en", m_en, 0); check("idle_m_we", m_we, 0);
      check("idle_i_ready", i_ready, 0); check("idle_d_ready", d_ready, 0);
      check("idle_i_rdata", i_rdata, e_ird); check("idle_d_rdata", d_rdata, e_drd);
    end
  end

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  initial begin
    int icnt, dcnt;
    bit first_d, ir, dr;
    for (int i = 0; i < int'(DEPTH); i++) begin
      ram[i]     = 32'hA500_0000 | i;
      ref_mem[i] = 32'hA500_0000 | i;
    end
    ram[4] = 32'h2001_0005; ref_mem[4] = 32'h2001_0005;

    // Requests present during reset must not reach the RAM.
    reset = 1; i_req = 0; i_addr = '0;
    d_req = 1; d_we = 1; d_addr = 32'h54; d_wdata = 32'h1234_5678;
    @(negedge clk);
    check("lit_rst_m_en", m_en, 0); check("lit_rst_m_addr", m_addr, 0);
    check("lit_rst_m_wdata", m_wdata, 0); check("lit_rst_d_rdata", d_rdata, 0);
    next_cycle(); reset = 0; d_req = 0;
    next_cycle();

    // Lone fetch of word 4.
    i_req = 1; i_addr = 32'h0000_0010;
    @(negedge clk); check("lit_fetch_m_en", m_en, 1); check("lit_fetch_m_addr", m_addr, 4);
    next_cycle();
    @(negedge clk); check("lit_fetch_ready", i_ready, 1); check("lit_fetch_rdata", i_rdata, 32'h2001_0005);
    next_cycle(); i_req = 0;
    @(negedge clk); check("lit_fetch_hold_rdy", i_ready, 0); check("lit_fetch_hold", i_rdata, 32'h2001_0005);

    // Data write then read of 0x54.
    next_cycle(); d_req = 1; d_we = 1; d_addr = 32'h54; d_wdata = 32'hDEAD_BEEF;
    @(negedge clk); check("lit_wr_m_we", m_we, 1); check("lit_wr_m_addr", m_addr, 21);
    next_cycle();
    @(negedge clk); check("lit_wr_ready", d_ready, 1);
    next_cycle(); d_we = 0;
    next_cycle();
    @(negedge clk); check("lit_rd_ready", d_ready, 1); check("lit_rd_rdata", d_rdata, 32'hDEAD_BEEF);

    // Both held for 8 cycles; data held continuously.
    next_cycle(); i_req = 1; i_addr = 32'h8; icnt = 0; dcnt = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk); icnt += int'(i_ready); dcnt += int'(d_ready);
      next_cycle();
    end
    check("lit_both_i_cnt", icnt, RR ? 2 : 0);
    check("lit_both_d_cnt", dcnt, RR ? 2 : 4);
    i_req = 0; d_req = 0;
    next_cycle();

    // Simultaneous request ordering: loser issued two cycles after winner.
    first_d = !RR;
    i_req = 1; d_req = 1;
    @(negedge clk); check("lit_order_first", m_addr, first_d ? 21 : 2);
    next_cycle();
    @(negedge clk); check("lit_order_rdy1", {i_ready, d_ready}, first_d ? 2'b01 : 2'b10);
    next_cycle(); if (first_d) d_req = 0; else i_req = 0;
    @(negedge clk); check("lit_order_second", m_addr, first_d ? 2 : 21);
    next_cycle();
    @(negedge clk); check("lit_order_rdy2", {i_ready, d_ready}, first_d ? 2'b10 : 2'b01);
    next_cycle(); i_req = 0; d_req = 0;

    // Address wrap, then reset during I_WAIT.
    next_cycle(); i_req = 1; i_addr = 32'h0000_0104;
    @(negedge clk); check("lit_wrap_m_addr", m_addr, 1);
    next_cycle(); reset = 1; i_req = 0;
    @(negedge clk); check("lit_rstw_i_ready", i_ready, 0); check("lit_rstw_i_rdata", i_rdata, 0);
    next_cycle(); reset = 0;
    @(negedge clk);
    check("lit_post_rst_outs", {i_ready, d_ready, m_en, m_we, m_addr, i_rdata, d_rdata}, 0);

    // Randomized traffic with occasional drops and resets.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk); ir = i_ready; dr = d_ready;
      next_cycle();
      if (reset) reset = 0;
      else if ($urandom_range(0, 79) == 0) reset = 1;
      if (ir || !i_req) begin
        i_req = $urandom_range(0, 1) == 1; i_addr = $urandom;
      end else if ($urandom_range(0, 29) == 0) i_req = 0;
      if (dr || !d_req) begin
        d_req = $urandom_range(0, 2) == 0; d_we = $urandom_range(0, 1) == 1;
        d_addr = $urandom; d_wdata = $urandom;
      end else if ($urandom_range(0, 29) == 0) d_req = 0;
    end
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
